// File: rtl/conv_core_param_if.sv
// Bus bundle for conv_core_param: control handshake, X/Y memory read ports and Z memory write port.
// The core connects through the slave modport; the controller/memory side uses master.
interface conv_core_param_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 5,
  parameter int OUT_ADDR_WIDTH = 6
);
  logic                      start;
  logic [31:0]               cfg;
  logic                      busy;
  logic                      done;
  logic [DATA_WIDTH-1:0]     dataX;
  logic [ADDR_WIDTH-1:0]     memX_addr;
  logic [DATA_WIDTH-1:0]     dataY;
  logic [ADDR_WIDTH-1:0]     memY_addr;
  logic [DATA_WIDTH-1:0]     dataZ;
  logic [OUT_ADDR_WIDTH-1:0] memZ_addr;
  logic                      writeZ;

  modport master (
    output start, cfg, dataX, dataY,
    input  busy, done, memX_addr, memY_addr, dataZ, memZ_addr, writeZ
  );

  modport slave (
    input  start, cfg, dataX, dataY,
    output busy, done, memX_addr, memY_addr, dataZ, memZ_addr, writeZ
  );
endinterface

// File: rtl/conv_core_param.sv
// Runtime-length signed 1-D convolution engine with a one-product-per-cycle MAC.
// Optional saturation of results is enabled by defining CONV_SAT_EN (adds the sat_flag output).
module conv_core_param #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 5,
  parameter int OUT_ADDR_WIDTH = 6
) (
  input  logic               clk,
  input  logic               rst_a,
  conv_core_param_if.slave   bus
`ifdef CONV_SAT_EN
  ,
  output logic               sat_flag
`endif
);
  localparam int DEPTH  = 1 << ADDR_WIDTH;
  localparam int SW     = ADDR_WIDTH + 1;
  localparam int NW     = OUT_ADDR_WIDTH + 1;
  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int ACC_W  = PROD_W + ADDR_WIDTH + 1;

`ifdef CONV_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  function automatic logic is_clipped(input logic signed [ACC_W-1:0] a);
    return (a > SAT_MAX) || (a < SAT_MIN);
  endfunction
`endif

  function automatic logic [DATA_WIDTH-1:0] to_result(input logic signed [ACC_W-1:0] a);
`ifdef CONV_SAT_EN
    if (a > SAT_MAX)      return SAT_MAX[DATA_WIDTH-1:0];
    else if (a < SAT_MIN) return SAT_MIN[DATA_WIDTH-1:0];
    else                  return a[DATA_WIDTH-1:0];
`else
    return a[DATA_WIDTH-1:0];
`endif
  endfunction

  function automatic logic [SW-1:0] clamp_len(input logic [SW-1:0] f);
    return (f > SW'(DEPTH)) ? SW'(DEPTH) : f;
  endfunction

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, DRAIN, WRITE, DONE} state_t;
  state_t state, state_nxt;

  logic [SW-1:0]             size_x, size_y, cfg_x, cfg_y;
  logic [OUT_ADDR_WIDTH-1:0] n;
  logic [ADDR_WIDTH-1:0]     addr_x, addr_y, khi;
  logic                      first_issue;
  logic [NW-1:0]             n_nxt, klo_nxt, khi_nxt, n_last;
  logic                      zero_len, issue_end, last_n;
  logic                      vld_p1, first_p1;
  logic signed [DATA_WIDTH-1:0] x_p1, y_p1;
  logic signed [PROD_W-1:0]  prod_p1;
  logic signed [ACC_W-1:0]   prod_ext_p1, acc_nxt, acc_p2;
  logic [DATA_WIDTH-1:0]     data_z;
  logic [OUT_ADDR_WIDTH-1:0] addr_z;
  logic                      unused_cfg;

  assign cfg_x      = clamp_len(bus.cfg[ADDR_WIDTH:0]);
  assign cfg_y      = clamp_len(bus.cfg[16+ADDR_WIDTH:16]);
  assign unused_cfg = ^bus.cfg;
  assign zero_len   = (cfg_x == '0) || (cfg_y == '0);
  assign issue_end  = (addr_x == khi);

  // Index window for the next output: k runs klo..khi, Y index is n-k.
  assign n_nxt   = NW'(n) + NW'(1);
  assign klo_nxt = (n_nxt + NW'(1) > NW'(size_y)) ? (n_nxt + NW'(1) - NW'(size_y)) : '0;
  assign khi_nxt = (n_nxt < NW'(size_x)) ? n_nxt : (NW'(size_x) - NW'(1));
  assign n_last  = NW'(size_x) + NW'(size_y) - NW'(2);
  assign last_n  = (NW'(n) == n_last);

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = LOAD;
      LOAD:    state_nxt = zero_len ? DONE : ISSUE;
      ISSUE:   if (issue_end) state_nxt = DRAIN;
      DRAIN:   state_nxt = WRITE;
      WRITE:   state_nxt = last_n ? DONE : ISSUE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      size_x      <= '0;
      size_y      <= '0;
      n           <= '0;
      addr_x      <= '0;
      addr_y      <= '0;
      khi         <= '0;
      first_issue <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          size_x <= cfg_x;
          size_y <= cfg_y;
          if (!zero_len) begin
            n           <= '0;
            addr_x      <= '0;
            addr_y      <= '0;
            khi         <= '0;
            first_issue <= 1'b1;
          end
        end
        ISSUE: begin
          first_issue <= 1'b0;
          if (!issue_end) begin
            addr_x <= addr_x + ADDR_WIDTH'(1);
            addr_y <= addr_y - ADDR_WIDTH'(1);
          end
        end
        WRITE: begin
          if (!last_n) begin
            n           <= OUT_ADDR_WIDTH'(n_nxt);
            addr_x      <= ADDR_WIDTH'(klo_nxt);
            addr_y      <= ADDR_WIDTH'(n_nxt - klo_nxt);
            khi         <= ADDR_WIDTH'(khi_nxt);
            first_issue <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Stage p1: memory data for the address issued last cycle; multiply.
  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      vld_p1   <= 1'b0;
      first_p1 <= 1'b0;
    end else begin
      vld_p1   <= (state == ISSUE);
      first_p1 <= (state == ISSUE) && first_issue;
    end
  end

  assign x_p1        = bus.dataX;
  assign y_p1        = bus.dataY;
  assign prod_p1     = x_p1 * y_p1;
  assign prod_ext_p1 = {{(ACC_W-PROD_W){prod_p1[PROD_W-1]}}, prod_p1};
  assign acc_nxt     = first_p1 ? prod_ext_p1 : (acc_p2 + prod_ext_p1);

  // Stage p2: accumulate; the final sum is formatted into the Z write register in DRAIN.
  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      acc_p2 <= '0;
      data_z <= '0;
      addr_z <= '0;
    end else begin
      if (state == WRITE)  acc_p2 <= '0;
      else if (vld_p1)     acc_p2 <= acc_nxt;
      if (state == DRAIN) begin
        data_z <= to_result(acc_nxt);
        addr_z <= n;
      end
    end
  end

`ifdef CONV_SAT_EN
  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a)                                      sat_flag <= 1'b0;
    else if (state == LOAD)                         sat_flag <= 1'b0;
    else if ((state == DRAIN) && is_clipped(acc_nxt)) sat_flag <= 1'b1;
  end
`endif

  assign bus.memX_addr = addr_x;
  assign bus.memY_addr = addr_y;
  assign bus.memZ_addr = addr_z;
  assign bus.dataZ     = data_z;
  assign bus.writeZ    = (state == WRITE);
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
endmodule

// File: doc/conv_core_param.md
Name: conv_core_param

Overview:
- Parametrised 1-D discrete convolution engine, Z[n] = sum over k of X[k]*Y[n-k], n = 0..sizeX+sizeY-2.
- Successor to the fixed-size dummy convolution core behind the AIP interface wrapper.
- Reads two input memories (X, Y) through read-address ports, writes results to output memory Z.
- Adds runtime lengths, signed arithmetic, pipelined MAC and an optional saturation mode.

Parameters:
DATA_WIDTH, 32, sample and result width (signed two's complement)
ADDR_WIDTH, 5, input memory address width; max input length DEPTH = 2^ADDR_WIDTH (ADDR_WIDTH <= 15)
OUT_ADDR_WIDTH, 6, output memory address width; must satisfy 2^OUT_ADDR_WIDTH >= 2*DEPTH-1

Ports:
clk  in  1  clock, all logic on rising edge
rst_a  in  1  asynchronous reset, active-high
start  in  1  single-cycle start request
dataX  in  DATA_WIDTH  X memory read data, valid 1 cycle after memX_addr
memX_addr  out  ADDR_WIDTH  X memory read address
dataY  in  DATA_WIDTH  Y memory read data, valid 1 cycle after memY_addr
memY_addr  out  ADDR_WIDTH  Y memory read address
dataZ  out  DATA_WIDTH  Z memory write data
memZ_addr  out  OUT_ADDR_WIDTH  Z memory write address
writeZ  out  1  Z write strobe, one cycle per result
config  in  32  [ADDR_WIDTH:0] = sizeX, [16+ADDR_WIDTH:16] = sizeY; other bits ignored
busy  out  1  operation in progress
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, active-high): state IDLE; busy, done, writeZ = 0; memX_addr, memY_addr, memZ_addr, dataZ = 0; accumulator cleared.
- Reset mid-operation: immediate abort to IDLE. No further writes. No done pulse.
- States:
  - IDLE: start=1 -> LOAD.
  - LOAD (1 cycle): latch sizeX and sizeY, each clamped to DEPTH. If either is 0 -> DONE with no writes. Otherwise n=0 -> ISSUE.
  - ISSUE (T(n) cycles): klo = max(0, n-sizeY+1), khi = min(n, sizeX-1), T(n) = khi-klo+1. Each cycle drive memX_addr=k, memY_addr=n-k for k = klo..khi.
  - DRAIN (1 cycle): last product accumulated.
  - WRITE (1 cycle): writeZ=1, memZ_addr=n, dataZ=result. Accumulator cleared. n==sizeX+sizeY-2 -> DONE, else n+1 -> ISSUE.
  - DONE (1 cycle): done=1 -> IDLE.
- MAC pipeline:
  - Product of data returned in cycle c is accumulated in cycle c+1.
  - First accumulate of each output overwrites the accumulator instead of adding.
- Arithmetic:
  - Product is signed 2*DATA_WIDTH bits.
  - Accumulator is signed 2*DATA_WIDTH+ADDR_WIDTH+1 bits; it never overflows.
  - Result is the low DATA_WIDTH bits (wrap), unless the optional feature is enabled.
- busy:
  - 1 from the LOAD cycle through the DONE cycle inclusive.
  - Falls together with the trailing edge of done.
- start is ignored unless in IDLE. config is sampled only in LOAD, so changes during an operation have no effect.
- Latency from the edge sampling start to the done cycle: 2 + sum over n of (T(n)+2). Zero-size case: 2.
- memX_addr and memY_addr hold their last value outside ISSUE.
- dataZ and memZ_addr hold their last written value.

Optional Feature:
- Macro CONV_SAT_EN.
- Defined: result saturates to the signed DATA_WIDTH range, [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. A sticky status register sat_flag (extra output port, 1 bit) sets on any clipped result and clears on the next LOAD.
- Undefined: wrap truncation. No sat_flag port.

Test Plan:
- Basic: X=[1,2,3], Y=[1,1], config sizeX=3, sizeY=2, start pulse -> writes Z[0..3]=[1,3,5,3] at addresses 0..3. done high exactly 16 cycles after the start edge. busy high for cycles 1..16.
- Signed: X=[-2,5], Y=[3,-4,1] -> Z=[-6,23,-22,5]. Exactly 4 writeZ pulses.
- Zero length: sizeX=0, sizeY=4 -> no writeZ. done pulses on cycle 2 after start.
- Clamp / full depth: DEPTH=32, sizeX field=40 (clamped to 32), sizeY=32, all samples 1 -> 63 writes; Z[n]=min(n+1, 63-n), e.g. Z[31]=32, Z[62]=1. Last memZ_addr=62.
- Abort: assert rst_a during the ISSUE for n=2 of the basic case -> all outputs 0 asynchronously, no done. A new start after release completes a full correct run.
- Overflow (DATA_WIDTH=8): X=[127,127], Y=[127,127] -> Z[1]=32258. Wrap build: dataZ=0x02. CONV_SAT_EN build: dataZ=127 and sat_flag=1.
